nim_trigger_logic: RTL and testbench
====================================

# nim_trigger_logic

Combines up to N_IN conditioned NIM trigger lines into one output trigger. Each line has already passed through its per-channel delay/stretch/invert stage. The block applies a channel mask, a majority coincidence, a veto and a prescale. On acceptance it emits a fixed-width output pulse, then enforces a programmable dead time. Hit and accept counters feed slow control. It sits between the per-channel input conditioning and the NIM output drivers.

## Interface
- N_IN, default 4: number of conditioned trigger inputs (1..16)
- CNT_W, default 32: width of the event counters
- clk  in  1  system clock; all inputs synchronous to it
- reset  in  1  synchronous, active-high
- trig_in  in  N_IN  conditioned trigger levels, one per channel
- enable  in  1  level; 0 suppresses new candidates
- mask  in  N_IN  1 = channel participates in coincidence
- majority  in  5  minimum number of masked channels high; 0 = never fire
- veto  in  1  level; rejects candidates while high
- prescale  in  16  accept one of every prescale+1 eligible candidates
- width  in  16  output pulse length in clk cycles; 0 treated as 1
- deadtime  in  32  cycles held busy after the pulse ends; 0 = none
- count_clear  in  1  single-cycle clear of both counters and the prescale counter
- trig_out  out  1  accepted trigger pulse
- busy  out  1  high in PULSE or DEAD
- raw_count  out  CNT_W  count of coincidence rising edges, including rejected ones
- accepted_count  out  CNT_W  count of pulses issued

## Operation
- Stage 1 (registered): coinc_r <= enable && majority != 0 && popcount(trig_in & mask) >= majority.
- Candidate (combinational from registers): cand = coinc_r && !coinc_r_d, where coinc_r_d is coinc_r delayed one cycle.
  - A held coincidence yields exactly one candidate.
  - A new candidate needs coinc_r to drop for at least 1 cycle.
- Every cand increments raw_count, regardless of state, veto or prescale.
- Eligible candidate: cand && state == IDLE && !veto.
  - Each eligible candidate advances a 16-bit prescale counter.
  - It is accepted when prescale_cnt == prescale; the counter then returns to 0, otherwise it increments.
  - Non-eligible candidates leave the prescale counter unchanged.
- FSM states, defined in the package: IDLE, PULSE, DEAD.
  - IDLE -> PULSE on acceptance. Load pulse counter with max(width,1)-1 and increment accepted_count.
  - PULSE: trig_out = 1. When the pulse counter reaches 0, go to DEAD if deadtime != 0 (load dead counter with deadtime-1), else go to IDLE.
  - DEAD: count down; go to IDLE on the cycle the counter is 0.
- width and deadtime are sampled at the moment of loading. Changes mid-pulse take effect on the next trigger.
- Deasserting enable or asserting veto during PULSE or DEAD does not truncate the cycle.
- Counters saturate at all ones.
- count_clear zeroes raw_count, accepted_count and prescale_cnt.
  - It wins over a simultaneous increment; the value in that cycle becomes 0.
  - It does not affect the FSM.
- Reset: state IDLE, trig_out 0, busy 0, all counters 0, coinc_r and coinc_r_d 0. Reset applied mid-pulse ends the pulse on the next edge.

## Timing
- Latency: trig_in meeting the coincidence with setup before edge k gives coinc_r = 1 after edge k and trig_out = 1 after edge k+1. That is 2 cycles input-to-output.
- trig_out and busy are registered outputs with no combinational path from inputs.
- Pulse: exactly max(width,1) cycles high. busy stays high for max(width,1) + deadtime cycles.
- Back-to-back: after returning to IDLE, a candidate in the first IDLE cycle is accepted.
  - Minimum trigger period = max(width,1) + deadtime + 1 cycles.
  - This requires coinc_r to re-edge.
- A candidate arriving in the same cycle the FSM leaves DEAD is not eligible, because state is still DEAD. It counts only toward raw_count.

## Structure
- Package nim_trig_pkg:
  - state typedef enum {IDLE, PULSE, DEAD}
  - localparams for the majority width (5), prescale width (16) and deadtime width (32)
- Sub-module nim_coinc: masked popcount plus majority compare plus the stage-1 register. Parameterized by N_IN.
- Top level holds the edge detect, the prescale counter, the FSM with its pulse/dead counters, and the saturating counters.

## Test plan
- Mask 4'b0011, majority 2, width 3, deadtime 0: pulse ch0 and ch1 together for 5 cycles -> one trig_out pulse of 3 cycles starting 2 cycles after the inputs; raw_count = 1, accepted_count = 1.
- Majority 2 with only ch0 high; then mask 0 with all channels high -> no trig_out, raw_count stays 0. Majority 0 with all channels high -> no trigger.
- Prescale 2, 9 isolated coincidences spaced well apart -> accepted_count = 3 (3rd, 6th, 9th), raw_count = 9.
- Width 2, deadtime 10, second coincidence arriving 5 cycles after the first -> second is rejected; busy is high for 12 cycles; raw_count = 2, accepted_count = 1. Same second coincidence at the minimum period of 13 cycles -> accepted.
- Veto high during one of 3 candidates -> accepted_count = 2; the prescale counter is not advanced by the vetoed candidate.
- Reset asserted in the 2nd cycle of a width-5 pulse -> trig_out = 0 after the next edge, all counters 0. count_clear coincident with an acceptance -> accepted_count reads 0 afterwards.

Source files
------------

// File: rtl/nim_trig_pkg.sv
// Shared types and field widths for the NIM trigger combiner.
package nim_trig_pkg;

  localparam int MAJ_W  = 5;
  localparam int PSC_W  = 16;
  localparam int DEAD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2
  } state_t;

endpackage

// File: rtl/nim_coinc.sv
// Masked majority coincidence with one register stage.
module nim_coinc
  import nim_trig_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  trig_in,
  input  logic [N_IN-1:0]  mask,
  input  logic             enable,
  input  logic [MAJ_W-1:0] majority,
  output logic             coinc_r
);

  logic [N_IN-1:0]  hit;
  logic [MAJ_W-1:0] hit_cnt;
  logic             coinc_next;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_hit
    assign hit[gi] = trig_in[gi] & mask[gi];
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      hit_cnt = hit_cnt + MAJ_W'(hit[i]);
    end
  end

  // majority 0 is the "never fire" setting, not "always fire"
  assign coinc_next = enable && (majority != '0) && (hit_cnt >= majority);

  always_ff @(posedge clk) begin
    if (reset) begin
      coinc_r <= 1'b0;
    end else begin
      coinc_r <= coinc_next;
    end
  end

endmodule

// File: rtl/nim_trigger_logic.sv
// Trigger combiner: coincidence edge, veto, prescale, fixed pulse plus dead time, counters.
module nim_trigger_logic
  import nim_trig_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   trig_in,
  input  logic              enable,
  input  logic [N_IN-1:0]   mask,
  input  logic [MAJ_W-1:0]  majority,
  input  logic              veto,
  input  logic [PSC_W-1:0]  prescale,
  input  logic [15:0]       width,
  input  logic [DEAD_W-1:0] deadtime,
  input  logic              count_clear,
  output logic              trig_out,
  output logic              busy,
  output logic [CNT_W-1:0]  raw_count,
  output logic [CNT_W-1:0]  accepted_count
);

  logic              coinc_r;
  logic              coinc_d_reg;
  logic              cand;
  logic              eligible;
  logic              accept;
  logic [PSC_W-1:0]  psc_cnt_reg;
  logic [15:0]       pulse_cnt_reg;
  logic [DEAD_W-1:0] dead_cnt_reg;
  logic [CNT_W-1:0]  raw_count_reg;
  logic [CNT_W-1:0]  acc_count_reg;
  state_t            state_reg;

  nim_coinc #(.N_IN(N_IN)) u_coinc (
    .clk      (clk),
    .reset    (reset),
    .trig_in  (trig_in),
    .mask     (mask),
    .enable   (enable),
    .majority (majority),
    .coinc_r  (coinc_r)
  );

  assign cand     = coinc_r && !coinc_d_reg;
  assign eligible = cand && (state_reg == IDLE) && !veto;
  assign accept   = eligible && (psc_cnt_reg == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      coinc_d_reg <= 1'b0;
    end else begin
      coinc_d_reg <= coinc_r;
    end
  end

  // count_clear takes priority over any same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || count_clear) begin
      psc_cnt_reg   <= '0;
      raw_count_reg <= '0;
      acc_count_reg <= '0;
    end else begin
      if (eligible) begin
        psc_cnt_reg <= accept ? '0 : psc_cnt_reg + 1'b1;
      end
      if (cand && (raw_count_reg != '1)) begin
        raw_count_reg <= raw_count_reg + 1'b1;
      end
      if (accept && (acc_count_reg != '1)) begin
        acc_count_reg <= acc_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      dead_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg     <= PULSE;
            pulse_cnt_reg <= (width == 16'd0) ? 16'd0 : width - 16'd1;
          end
        end
        PULSE: begin
          if (pulse_cnt_reg == 16'd0) begin
            if (deadtime != '0) begin
              state_reg    <= DEAD;
              dead_cnt_reg <= deadtime - 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg - 16'd1;
          end
        end
        DEAD: begin
          if (dead_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            dead_cnt_reg <= dead_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trig_out       = (state_reg == PULSE);
  assign busy           = (state_reg != IDLE);
  assign raw_count      = raw_count_reg;
  assign accepted_count = acc_count_reg;

endmodule

// File: tb/tb_nim_trigger_logic.sv
// Directed bench for nim_trigger_logic with a timeline-based reference model.
module tb_nim_trigger_logic;
  localparam int N_IN  = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_IN-1:0]  trig_in = '0;
  logic             enable = 1'b1;
  logic [N_IN-1:0]  mask = '0;
  logic [4:0]       majority = '0;
  logic             veto = 1'b0;
  logic [15:0]      prescale = '0;
  logic [15:0]      width = 16'd1;
  logic [31:0]      deadtime = '0;
  logic             count_clear = 1'b0;
  logic             trig_out, busy;
  logic [CNT_W-1:0] raw_count, accepted_count;

  nim_trigger_logic #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .trig_in        (trig_in),
    .enable         (enable),
    .mask           (mask),
    .majority       (majority),
    .veto           (veto),
    .prescale       (prescale),
    .width          (width),
    .deadtime       (deadtime),
    .count_clear    (count_clear),
    .trig_out       (trig_out),
    .busy           (busy),
    .raw_count      (raw_count),
    .accepted_count (accepted_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
  endtask

  // Model: the output timeline is kept as the edge indices at which the pulse
  // and busy windows end, not as a state machine.
  int  edge_n = 0;
  bit  m_started = 0;
  bit  m_coinc = 0, m_coinc_d = 0;
  int  m_raw = 0, m_acc = 0;
  int  m_psc = 0;
  int  pulse_end = -1, busy_end = -1;
  bit  exp_trig = 0, exp_busy = 0;

  always @(posedge clk) begin
    bit cand, idle, elig, acc;
    int w;
    edge_n++;
    if (reset) begin
      m_coinc = 0; m_coinc_d = 0;
      m_raw = 0; m_acc = 0; m_psc = 0;
      pulse_end = -1; busy_end = -1;
    end else begin
      cand = m_coinc && !m_coinc_d;
      idle = (edge_n - 1) > busy_end;
      elig = cand && idle && !veto;
      acc  = elig && (m_psc == int'(prescale));
      if (cand && m_raw < CMAX) m_raw++;
      if (acc && m_acc < CMAX) m_acc++;
      if (elig) m_psc = acc ? 0 : (m_psc + 1) % 65536;
      if (count_clear) begin m_raw = 0; m_acc = 0; m_psc = 0; end
      if (acc) begin
        w = (width == 0) ? 1 : int'(width);
        pulse_end = edge_n + w - 1;
        busy_end  = edge_n + w + int'(deadtime) - 1;
      end
      m_coinc_d = m_coinc;
      m_coinc = enable && (majority != 0) && ($countones(trig_in & mask) >= int'(majority));
    end
    exp_trig = (edge_n <= pulse_end);
    exp_busy = (edge_n <= busy_end);
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("trig_out", trig_out, exp_trig);
      chk("busy", busy, exp_busy);
      chk("raw_count", raw_count, m_raw);
      chk("accepted_count", accepted_count, m_acc);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_clear();
    count_clear = 1'b1; tick(1); count_clear = 1'b0; tick(1);
  endtask

  // Two single-cycle coincidences gap cycles apart; returns busy-high cycle count.
  task automatic two_hits(input int gap, output int bc);
    bc = 0;
    trig_in = 4'b0011;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      trig_in = (i == gap) ? 4'b0011 : 4'b0000;
      if (busy) bc++;
    end
  endtask

  initial begin
    int bc;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("reset_trig", trig_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_raw", raw_count, 0);

    // basic coincidence, latency and pulse length
    mask = 4'b0011; majority = 5'd2; width = 16'd3; deadtime = 0;
    trig_in = 4'b0011;
    tick(1); chk("t1_lat1", trig_out, 0);
    tick(1); chk("t1_start", trig_out, 1);
    tick(2); chk("t1_3rd", trig_out, 1);
    tick(1); chk("t1_end", trig_out, 0);
    trig_in = '0; tick(5);
    chk("t1_raw", raw_count, 1);
    chk("t1_acc", accepted_count, 1);

    // no-fire cases
    do_clear();
    trig_in = 4'b0001; tick(5); trig_in = '0; tick(3);
    mask = 4'b0000; trig_in = 4'b1111; tick(5); trig_in = '0; tick(3);
    mask = 4'b1111; majority = 5'd0; trig_in = 4'b1111; tick(5); trig_in = '0; tick(3);
    chk("t2_raw", raw_count, 0);
    chk("t2_acc", accepted_count, 0);

    // prescale 2
    mask = 4'b0011; majority = 5'd2; width = 16'd1; prescale = 16'd2;
    do_clear();
    for (int j = 0; j < 9; j++) begin
      trig_in = 4'b0011; tick(2); trig_in = '0; tick(4);
    end
    chk("t3_raw", raw_count, 9);
    chk("t3_acc", accepted_count, 3);

    // dead time: gap 5 rejected, gap 12 leaves DEAD, gap 13 accepted
    prescale = 0; width = 16'd2; deadtime = 32'd10;
    do_clear();
    two_hits(5, bc);
    chk("t4_busy_cycles", bc, 12);
    chk("t4_raw", raw_count, 2);
    chk("t4_acc", accepted_count, 1);
    do_clear();
    two_hits(12, bc);
    chk("t4_gap12_acc", accepted_count, 1);
    do_clear();
    two_hits(13, bc);
    chk("t4_gap13_acc", accepted_count, 2);
    chk("t4_gap13_busy", bc, 24);

    // veto on middle of three candidates
    width = 16'd1; deadtime = 0;
    for (int p = 0; p < 2; p++) begin
      prescale = 16'(p);
      do_clear();
      for (int j = 0; j < 3; j++) begin
        veto = (j == 1); trig_in = 4'b0011; tick(3);
        veto = 1'b0; trig_in = '0; tick(3);
      end
      chk("t5_raw", raw_count, 3);
      chk(p == 0 ? "t5_acc_p0" : "t5_acc_p1", accepted_count, 2 - p);
    end

    // reset in 2nd pulse cycle
    prescale = 0; width = 16'd5;
    trig_in = 4'b0011; tick(1); trig_in = '0;
    tick(2); chk("t6_pulse", trig_out, 1);
    reset = 1'b1; tick(1);
    chk("t6_trig", trig_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_raw", raw_count, 0);
    chk("t6_acc", accepted_count, 0);
    reset = 1'b0; tick(3);

    // count_clear coincident with acceptance
    trig_in = 4'b0011; tick(1);
    trig_in = '0; count_clear = 1'b1; tick(1);
    count_clear = 1'b0;
    chk("t6_clr_trig", trig_out, 1);
    chk("t6_clr_acc", accepted_count, 0);
    tick(8);

    // width 0 behaves as 1
    width = 16'd0;
    trig_in = 4'b0011; tick(2); chk("t7_w0_on", trig_out, 1);
    tick(1); chk("t7_w0_off", trig_out, 0);
    trig_in = '0; tick(3);

    // saturation
    width = 16'd1;
    do_clear();
    for (int j = 0; j < 260; j++) begin
      trig_in = 4'b0011; tick(1); trig_in = '0; tick(1);
    end
    tick(3);
    chk("t8_raw_sat", raw_count, CMAX);
    chk("t8_acc_sat", accepted_count, CMAX);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
